// File: rtl/discrete_sample_mixer_if.sv
// Sample-bus bundle between the sound circuits (master) and the discrete sample mixer (slave).
// Handshake: audio_clk_en is a one-clk strobe with no ready; out_valid is a one-clk pulse with no ready.
interface discrete_sample_mixer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SIGNAL_WIDTH = 16,
  parameter int GAIN_WIDTH   = 8
) ();
  logic                                      audio_clk_en;
  logic [NUM_CHANNELS-1:0][SIGNAL_WIDTH-1:0] in_samples;
  logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0]   gains;
  logic [NUM_CHANNELS-1:0]                   mute;
  logic signed [SIGNAL_WIDTH-1:0]            out;
  logic                                      out_valid;
  logic                                      busy;
  logic [7:0]                                clip_count;
  logic [7:0]                                overrun_count;

  modport master (
    output audio_clk_en, in_samples, gains, mute,
    input  out, out_valid, busy, clip_count, overrun_count
  );

  modport slave (
    input  audio_clk_en, in_samples, gains, mute,
    output out, out_valid, busy, clip_count, overrun_count
  );
endinterface

// File: rtl/discrete_sample_mixer.sv
// Snapshots all channel samples on audio_clk_en, mixes them through one shared
// signed x unsigned MAC (one channel per clock), then saturates and emits one sample.
module discrete_sample_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SIGNAL_WIDTH = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int GAIN_SHIFT   = 7
) (
  input  logic                         clk,
  input  logic                         I_RST,
  discrete_sample_mixer_if.slave       bus,
  output logic [1:0]                   state_dbg
);

  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = SIGNAL_WIDTH + GAIN_WIDTH + 1;
  localparam int ACC_W  = SIGNAL_WIDTH + GAIN_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SIGNAL_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SIGNAL_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                                    state_q, state_d;
  logic [IDX_W-1:0]                          idx_q, idx_d;
  logic signed [ACC_W-1:0]                   acc_q, acc_d;
  logic [NUM_CHANNELS-1:0][SIGNAL_WIDTH-1:0] snap_sample_q, snap_sample_d;
  logic [NUM_CHANNELS-1:0][GAIN_WIDTH-1:0]   snap_gain_q, snap_gain_d;
  logic [NUM_CHANNELS-1:0]                   snap_mute_q, snap_mute_d;
  logic signed [SIGNAL_WIDTH-1:0]            out_q, out_d;
  logic                                      out_valid_q, out_valid_d;
  logic                                      busy_q, busy_d;
  logic [7:0]                                clip_q, clip_d;
  logic [7:0]                                overrun_q, overrun_d;

  logic signed [SIGNAL_WIDTH-1:0] cur_sample;
  logic [GAIN_WIDTH-1:0]          cur_gain;
  logic                           cur_mute;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        term;
  logic signed [ACC_W-1:0]        scaled;
  logic                           sat_hi, sat_lo;

  // Gain is zero-extended so 255 stays positive; accumulator is sized so it cannot wrap.
  always_comb begin
    cur_sample = snap_sample_q[idx_q];
    cur_gain   = snap_gain_q[idx_q];
    cur_mute   = snap_mute_q[idx_q];
    prod       = cur_sample * $signed({1'b0, cur_gain});
    term       = cur_mute ? '0 : {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    scaled     = acc_q >>> GAIN_SHIFT;
    sat_hi     = (scaled > SAT_MAX);
    sat_lo     = (scaled < SAT_MIN);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    snap_sample_d = snap_sample_q;
    snap_gain_d   = snap_gain_q;
    snap_mute_d   = snap_mute_q;
    out_d         = out_q;
    out_valid_d   = 1'b0;
    busy_d        = busy_q;
    clip_d        = clip_q;
    overrun_d     = overrun_q;

    // Any strobe outside IDLE (including the OUTPUT cycle) is dropped and counted.
    if (state_q != IDLE && bus.audio_clk_en && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.audio_clk_en) begin
          snap_sample_d = bus.in_samples;
          snap_gain_d   = bus.gains;
          snap_mute_d   = bus.mute;
          acc_d         = '0;
          idx_d         = '0;
          busy_d        = 1'b1;
          state_d       = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (sat_hi) begin
          out_d = SAT_MAX[SIGNAL_WIDTH-1:0];
        end else if (sat_lo) begin
          out_d = SAT_MIN[SIGNAL_WIDTH-1:0];
        end else begin
          out_d = scaled[SIGNAL_WIDTH-1:0];
        end
        if ((sat_hi || sat_lo) && clip_q != 8'hFF) begin
          clip_d = clip_q + 8'd1;
        end
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      snap_sample_q <= '0;
      snap_gain_q   <= '0;
      snap_mute_q   <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      clip_q        <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      snap_sample_q <= snap_sample_d;
      snap_gain_q   <= snap_gain_d;
      snap_mute_q   <= snap_mute_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      clip_q        <= clip_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.out           = out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.busy          = busy_q;
  assign bus.clip_count    = clip_q;
  assign bus.overrun_count = overrun_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_discrete_sample_mixer.sv
// Directed bench for discrete_sample_mixer: hand-computed vectors checked with immediate assertions.
module tb_discrete_sample_mixer;

  logic       clk;
  logic       I_RST;
  logic [1:0] state_dbg;
  int         vectors;
  int         miscompares;

  discrete_sample_mixer_if #(.NUM_CHANNELS(4), .SIGNAL_WIDTH(16), .GAIN_WIDTH(8)) bus ();

  discrete_sample_mixer #(
    .NUM_CHANNELS(4), .SIGNAL_WIDTH(16), .GAIN_WIDTH(8), .GAIN_SHIFT(7)
  ) dut (
    .clk       (clk),
    .I_RST     (I_RST),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int s0, input int s1, input int s2, input int s3,
                         input int g0, input int g1, input int g2, input int g3,
                         input logic [3:0] m);
    bus.in_samples[0] = 16'(s0);
    bus.in_samples[1] = 16'(s1);
    bus.in_samples[2] = 16'(s2);
    bus.in_samples[3] = 16'(s3);
    bus.gains[0] = 8'(g0);
    bus.gains[1] = 8'(g1);
    bus.gains[2] = 8'(g2);
    bus.gains[3] = 8'(g3);
    bus.mute = m;
  endtask

  // Strobe sampled at edge T; returns just after T.
  task automatic strobe(input string tag);
    bus.audio_clk_en = 1'b1;
    tick();
    bus.audio_clk_en = 1'b0;
    chk({tag, "_busy_start"}, int'(bus.busy), 1);
  endtask

  // Runs edges T+1..T+6 and checks timing and result of the mix.
  task automatic finish_mix(input string tag, input int exp_out);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk({tag, "_accum_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_accum_busy"}, int'(bus.busy), 1);
    end
    tick();
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_out"}, int'(bus.out), exp_out);
    chk({tag, "_busy_end"}, int'(bus.busy), 0);
    tick();
    chk({tag, "_valid_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_out_hold"}, int'(bus.out), exp_out);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    I_RST = 1'b1;
    bus.audio_clk_en = 1'b0;
    set_all(0, 0, 0, 0, 128, 128, 128, 128, 4'b0000);

    // reset, with a strobe during reset that must be ignored
    tick();
    bus.audio_clk_en = 1'b1;
    tick();
    bus.audio_clk_en = 1'b0;
    I_RST = 1'b0;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_clip", int'(bus.clip_count), 0);
    chk("rst_overrun", int'(bus.overrun_count), 0);
    chk("rst_state", int'(state_dbg), 0);
    tick();
    chk("rst_strobe_ignored", int'(bus.busy), 0);

    // unity, single channel
    set_all(1000, 0, 0, 0, 128, 128, 128, 128, 4'b0000);
    strobe("unity");
    finish_mix("unity", 1000);

    // positive then negative saturation
    set_all(20000, 20000, 0, 0, 128, 128, 128, 128, 4'b0000);
    strobe("sat_pos");
    finish_mix("sat_pos", 32767);
    chk("sat_pos_clip", int'(bus.clip_count), 1);
    set_all(-20000, -20000, -20000, 0, 128, 128, 128, 128, 4'b0000);
    strobe("sat_neg");
    finish_mix("sat_neg", -32768);
    chk("sat_neg_clip", int'(bus.clip_count), 2);

    // gain rounding toward -inf
    set_all(-3, 0, 0, 0, 64, 128, 128, 128, 4'b1110);
    strobe("round_neg");
    finish_mix("round_neg", -2);
    set_all(3, 0, 0, 0, 64, 128, 128, 128, 4'b1110);
    strobe("round_pos");
    finish_mix("round_pos", 1);
    chk("round_clip", int'(bus.clip_count), 2);

    // mixed gains: 1000*128 - 3000*255 + 500*64 + 0 = -605000; >>>7 = -4727
    set_all(1000, -3000, 500, 250, 128, 255, 64, 0, 4'b0000);
    strobe("mixed");
    finish_mix("mixed", -4727);

    // gain 0 acts as mute
    set_all(5000, 100, 200, 300, 0, 128, 128, 128, 4'b0000);
    strobe("gain0");
    finish_mix("gain0", 600);

    // full-scale negative at gain 255 on every channel: must not wrap
    set_all(-32768, -32768, -32768, -32768, 255, 255, 255, 255, 4'b0000);
    strobe("full_neg");
    finish_mix("full_neg", -32768);
    chk("full_neg_clip", int'(bus.clip_count), 3);

    // mute and snapshot isolation
    set_all(500, 700, 0, 0, 128, 128, 128, 128, 4'b0010);
    strobe("snap");
    set_all(9999, 9999, 9999, 9999, 255, 255, 255, 255, 4'b0000);
    finish_mix("snap", 500);

    // overrun during ACCUM
    set_all(1234, 0, 0, 0, 128, 128, 128, 128, 4'b0000);
    strobe("ovr1");
    tick();
    bus.audio_clk_en = 1'b1;
    bus.in_samples[0] = 16'(7777);
    tick();
    bus.audio_clk_en = 1'b0;
    chk("ovr1_count", int'(bus.overrun_count), 1);
    chk("ovr1_busy", int'(bus.busy), 1);
    tick();
    tick();
    chk("ovr1_no_early_valid", int'(bus.out_valid), 0);
    tick();
    chk("ovr1_valid", int'(bus.out_valid), 1);
    chk("ovr1_out", int'(bus.out), 1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovr1_single_valid", int'(bus.out_valid), 0);
    end
    chk("ovr1_idle", int'(bus.busy), 0);

    // overrun in the OUTPUT cycle
    set_all(4321, 0, 0, 0, 128, 128, 128, 128, 4'b0000);
    strobe("ovr2");
    repeat (4) tick();
    chk("ovr2_state_output", int'(state_dbg), 2);
    bus.audio_clk_en = 1'b1;
    tick();
    bus.audio_clk_en = 1'b0;
    chk("ovr2_valid", int'(bus.out_valid), 1);
    chk("ovr2_out", int'(bus.out), 4321);
    chk("ovr2_count", int'(bus.overrun_count), 2);
    tick();
    chk("ovr2_no_new_mix", int'(bus.busy), 0);
    chk("ovr2_state_idle", int'(state_dbg), 0);

    // reset mid-mix
    set_all(3000, 0, 0, 0, 128, 128, 128, 128, 4'b0000);
    strobe("rstmid");
    tick();
    tick();
    I_RST = 1'b1;
    tick();
    I_RST = 1'b0;
    chk("rstmid_out", int'(bus.out), 0);
    chk("rstmid_valid", int'(bus.out_valid), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_clip", int'(bus.clip_count), 0);
    chk("rstmid_overrun", int'(bus.overrun_count), 0);
    chk("rstmid_state", int'(state_dbg), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_valid", int'(bus.out_valid), 0);
    end

    // normal mix after reset
    set_all(100, 200, 300, 400, 128, 128, 128, 128, 4'b0000);
    strobe("post_rst");
    finish_mix("post_rst", 1000);
    chk("post_rst_clip", int'(bus.clip_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/discrete_sample_mixer.md
Name: discrete_sample_mixer

Overview:
Consumer end of the discrete-sound sample interface. Each sound circuit (walk, jump, stomp, ...) presents a signed 16-bit sample that updates on audio_clk_en; this block latches all channel samples on that strobe and mixes them with per-channel gain and mute. Mixing is time-multiplexed through one shared multiply-accumulate, one channel per clock. The block then saturates the sum and emits one mixed sample with a valid pulse toward the board-level audio output.

Parameters:
NUM_CHANNELS, 4, number of sound-circuit inputs (1..16)
SIGNAL_WIDTH, 16, signed sample width for inputs and output
GAIN_WIDTH, 8, unsigned per-channel gain width; gain/128 = linear factor (128 = unity, 255 ≈ 1.99)
GAIN_SHIFT, 7, right shift applied to the accumulated sum (binary point of gain)

Ports:
clk  in  1  system clock
I_RST  in  1  synchronous reset, active-high
audio_clk_en  in  1  sample strobe, one clk wide, shared with the sound circuits
in_samples  in  NUM_CHANNELS x SIGNAL_WIDTH  signed channel samples
gains  in  NUM_CHANNELS x GAIN_WIDTH  unsigned per-channel gain
mute  in  NUM_CHANNELS  1 = channel contributes 0
out  out  SIGNAL_WIDTH  signed mixed sample, registered
out_valid  out  1  one-cycle pulse when out updates
busy  out  1  high while a mix is in progress
clip_count  out  8  saturating count of clipped output samples
overrun_count  out  8  saturating count of strobes dropped while busy

Behaviour:
- One clock; all state changes on posedge clk. I_RST is synchronous and active-high, and has priority over everything else.
- Reset values: out=0, out_valid=0, busy=0, clip_count=0, overrun_count=0, accumulator=0, state=IDLE.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE: when audio_clk_en=1, capture in_samples, gains and mute into snapshot registers. Clear accumulator, set channel index=0, set busy=1, go to ACCUM. Later changes on the inputs do not affect this mix.
- ACCUM: each cycle, acc += snapshot_sample[idx] * snapshot_gain[idx] (signed x unsigned, gain zero-extended). A muted channel adds 0. Increment idx. After idx = NUM_CHANNELS-1, go to OUTPUT.
- Accumulator width = SIGNAL_WIDTH + GAIN_WIDTH + ceil(log2(NUM_CHANNELS)) + 1. The accumulator must never wrap.
- OUTPUT: scaled = acc >>> GAIN_SHIFT (arithmetic shift, floor toward -inf).
  - If scaled > 32767, out=32767. If scaled < -32768, out=-32768. Otherwise out=scaled.
  - out_valid=1 for this one cycle.
  - If the sample saturated, clip_count increments, holding at 255.
  - busy=0; return to IDLE.
- Latency: strobe sampled at edge T; ACCUM occupies edges T+1..T+NUM_CHANNELS; out and out_valid are set at edge T+NUM_CHANNELS+1.
- out holds its value between mixes. out_valid is 0 except in the OUTPUT cycle.
- audio_clk_en=1 while in ACCUM or OUTPUT: the strobe is ignored and overrun_count increments, holding at 255. The mix in progress is unaffected.
- The OUTPUT cycle is not IDLE. A strobe arriving in that same cycle is an overrun; it does not start a new mix.
- Integration requirement: CLOCK_RATE/SAMPLE_RATE ≥ NUM_CHANNELS+2, so overruns never occur in normal use.
- Reset asserted mid-mix: abort immediately, no out_valid, all outputs return to reset values. A strobe in the same cycle as reset is ignored.
- Gain 0 behaves like mute. Gain 255 on -32768 must accumulate exactly, with no intermediate overflow.

Test Plan:
- Unity, single channel: gains={128,128,128,128}, samples={1000,0,0,0}, strobe -> out=1000 and out_valid pulse exactly 5 clk after the strobe edge; busy high for 5 cycles.
- Saturation, positive: samples={20000,20000,0,0}, unity gains -> out=32767, clip_count=1. Then samples={-20000,-20000,-20000,0} -> out=-32768, clip_count=2.
- Gain rounding: channel 0 sample=-3, gain=64, others muted -> -192>>>7 = -2; out=-2. Same with sample=+3 -> out=1.
- Mute and snapshot: samples={500,700,0,0}, mute=0b0010; change samples to {9999,...} one cycle after the strobe -> out=500.
- Overrun: strobe, then a second strobe 2 cycles later -> only one out_valid, out reflects the first snapshot, overrun_count=1. Strobe exactly 5 cycles after the first (OUTPUT cycle) -> overrun_count=2.
- Reset mid-mix: strobe, then I_RST=1 on the cycle after the second ACCUM edge -> no out_valid; out=0, busy=0, counters=0 on the next edge. A later strobe mixes normally.
